bit_deserializer: RTL and testbench

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

---
 rtl/bit_deserializer_if.sv | 26 ++
 rtl/bit_deserializer.sv | 137 +++++++++++++
 tb/tb_bit_deserializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_deserializer_if.sv
// Bundles the serial input, the parallel output handshake and the status flags
// of bit_deserializer. The slave modport is the deserializer's view; the master
// modport is the producer/consumer side that drives bits and accepts words.
interface bit_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             any_set;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport slave (
        input  din, din_valid, dout_ready,
        output dout, dout_valid, any_set, busy, overrun, parity_err
    );

    modport master (
        output din, din_valid, dout_ready,
        input  dout, dout_valid, any_set, busy, overrun, parity_err
    );
endinterface

// File: rtl/bit_deserializer.sv
// bit_deserializer: collects LSB-first serial bits into WIDTH-bit words and
// hands them out through a one-deep valid/ready output register.
// A completed word that finds the output register occupied (and not being
// consumed) is dropped and the sticky overrun flag is raised.
// Optional feature macro: PARITY_CHECK_EN -- each word carries one trailing
// even-parity bit; words failing the check are discarded and parity_err pulses.
module bit_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    bit_deserializer_if.slave bus
);

`ifdef PARITY_CHECK_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS);

    typedef enum logic {
        COLLECT = 1'b0,
        SHIFT   = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [NBITS-1:0] r_shift;
    logic             r_busy;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_any_set;
    logic             r_overrun;

    logic [NBITS-1:0] w_word;
    logic             w_last;
    logic             w_good;
    logic             w_space;

    // The sampled bit on the final edge is merged here so the whole word is
    // available in the same cycle it completes.
    always_comb begin
        w_word          = r_shift;
        w_word[r_count] = bus.din;
    end

    assign w_last  = bus.din_valid && (r_count == CW'(NBITS - 1));
    // Output register can take a word if empty or emptied on this very edge.
    assign w_space = !r_dout_valid || bus.dout_ready;

`ifdef PARITY_CHECK_EN
    logic w_par_ok;
    logic r_parity_err;

    // Data plus parity must contain an even number of ones.
    assign w_par_ok = ~^w_word;
    assign w_good   = w_last && w_par_ok;

    // One-cycle pulse following the final edge of a word that failed parity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_last && !w_par_ok;
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign w_good         = w_last;
    assign bus.parity_err = 1'b0;
`endif

    // Bit-collection FSM: counter, shift register and registered busy flag.
    // Since NBITS >= 2, the first bit of a word is never its final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= COLLECT;
            r_count <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else if (bus.din_valid) begin
            r_shift <= w_word;
            case (r_state)
                COLLECT: begin
                    r_state <= SHIFT;
                    r_busy  <= 1'b1;
                    r_count <= CW'(1);
                end
                SHIFT: begin
                    if (w_last) begin
                        r_state <= COLLECT;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    r_state <= COLLECT;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Output register: load on completion when there is room, clear on
    // consume, otherwise hold; a completion with no room raises overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_any_set    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_good && w_space) begin
                r_dout       <= w_word[WIDTH-1:0];
                r_any_set    <= |w_word[WIDTH-1:0];
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end
            if (w_good && !w_space) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.any_set    = r_any_set;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_bit_deserializer.sv
// Testbench for bit_deserializer: directed scenarios followed by random
// traffic; a word-level reference model feeds a scoreboard queue and a
// negedge monitor compares the DUT against it every cycle.
module tb_bit_deserializer;
    localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bit_deserializer_if #(.WIDTH(WIDTH)) bus ();
    bit_deserializer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] expq[$];
    bit               bitq[$];
    bit               m_full = 0;
    bit               m_ovr  = 0;
    bit               m_perr = 0;
    bit               mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: gathers sampled bits into a list; when a full word's
    // worth has arrived it is judged (parity) and either queued as the next
    // expected output, or dropped as an overrun if the output slot is taken.
    always @(posedge clk) begin : model
        logic [WIDTH-1:0] w;
        int               ones;
        bit               done;
        bit               ok;
        if (!rst_n) begin
            bitq.delete();
            expq.delete();
            m_full = 0;
            m_ovr  = 0;
            m_perr = 0;
        end else begin
            m_perr = 0;
            done   = 0;
            ok     = 1;
            w      = '0;
            if (bus.din_valid) begin
                bitq.push_back(bus.din);
                if (bitq.size() == NBITS) begin
                    ones = 0;
                    for (int i = 0; i < NBITS; i++) begin
                        ones += int'(bitq[i]);
                        if (i < WIDTH && bitq[i]) w = w | WIDTH'(1 << i);
                    end
                    ok   = (NBITS == WIDTH) || (ones % 2 == 0);
                    done = 1;
                    bitq.delete();
                end
            end
            if (done && !ok) m_perr = 1;
            if (done && ok) begin
                if (!m_full || bus.dout_ready) begin
                    expq.push_back(w);
                    m_full = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_full && bus.dout_ready) begin
                m_full = 0;
            end
        end
    end

    // Monitor: flag checks every cycle, word checks whenever dout is presented.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("dout_valid", 32'(bus.dout_valid), 32'(m_full));
            chk("busy", 32'(bus.busy), 32'(bitq.size() != 0));
            chk("overrun", 32'(bus.overrun), 32'(m_ovr));
            chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
            if (bus.dout_valid) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dout_unexpected: got %0h expected no word at %0t", bus.dout, $time);
                end else begin
                    chk("dout", 32'(bus.dout), 32'(expq[0]));
                    chk("any_set", 32'(bus.any_set), 32'(|expq[0]));
                    if (bus.dout_ready) begin
                        $display("word consumed: dout=%02h any_set=%0d at %0t", bus.dout, bus.any_set, $time);
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.din_valid = 1'b0;
        end
    endtask

    // Drives one word LSB first (plus parity bit when enabled). gap = idle
    // cycles after each bit; last_ready >= 0 sets dout_ready with the last bit.
    task automatic send_word(input logic [WIDTH-1:0] d, input int gap, input bit bad,
                             input int last_ready);
        logic [WIDTH:0]   full;
        logic [NBITS-1:0] v;
        full = {(^d) ^ bad, d};
        v    = full[NBITS-1:0];
        for (int i = 0; i < NBITS; i++) begin
            @(posedge clk); #1;
            bus.din       = v[i];
            bus.din_valid = 1'b1;
            if (i == NBITS - 1 && last_ready >= 0) bus.dout_ready = last_ready[0];
            if (i != NBITS - 1 && gap > 0) idle(gap);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n         = 1'b0;
        bus.din_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_en = 1;
        @(negedge clk);
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_any_set", 32'(bus.any_set), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // V1: continuous 0xA5 with consumer always ready
        bus.dout_ready = 1'b1;
        send_word(8'hA5, 0, 0, -1);
        idle(3);

        // V2: 0x00 with a gap after every bit
        send_word(8'h00, 1, 0, -1);
        idle(3);

        // V3: two words into a stalled consumer, then drain
        bus.dout_ready = 1'b0;
        send_word(8'h3C, 0, 0, -1);
        send_word(8'hFF, 0, 0, -1);
        idle(2);
        @(negedge clk);
        chk("v3_overrun", 32'(bus.overrun), 32'h1);
        chk("v3_dout_held", 32'(bus.dout), 32'h3C);
        @(posedge clk); #1;
        bus.dout_ready = 1'b1;
        idle(2);
        @(negedge clk);
        chk("v3_overrun_sticky", 32'(bus.overrun), 32'h1);
        chk("v3_drained", 32'(bus.dout_valid), 32'h0);

        // V4: consume on exactly the edge the next word completes
        do_reset();
        bus.dout_ready = 1'b0;
        send_word(8'h11, 0, 0, -1);
        idle(2);
        send_word(8'h22, 0, 0, 1);
        @(posedge clk); #1;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        @(negedge clk);
        chk("v4_dout", 32'(bus.dout), 32'h22);
        chk("v4_valid", 32'(bus.dout_valid), 32'h1);
        chk("v4_overrun", 32'(bus.overrun), 32'h0);
        bus.dout_ready = 1'b1;
        idle(2);

        // V5: reset in the middle of 0xF0, then a clean 0x0F
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.din       = 1'(8'hF0 >> i);
            bus.din_valid = 1'b1;
        end
        @(posedge clk); #1;
        rst_n         = 1'b0;
        bus.din       = 1'b1;
        bus.din_valid = 1'b1;
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.din_valid = 1'b0;
        send_word(8'h0F, 0, 0, -1);
        idle(1);
        @(negedge clk);
        chk("v5_dout", 32'(bus.dout), 32'h0F);
        idle(2);

`ifdef PARITY_CHECK_EN
        // V6: good parity accepted, bad parity rejected
        send_word(8'h07, 0, 0, -1);
        send_word(8'h07, 0, 1, -1);
        idle(1);
        @(negedge clk);
        chk("v6_parity_err", 32'(bus.parity_err), 32'h1);
        chk("v6_no_valid", 32'(bus.dout_valid), 32'h0);
        idle(2);
`endif

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.din        = 1'($urandom);
            bus.din_valid  = ($urandom_range(0, 3) != 0);
            bus.dout_ready = ($urandom_range(0, 2) != 0);
            rst_n          = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk); #1;
        rst_n          = 1'b1;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        idle(4);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
